// File: rtl/rom_arbiter_pkg.sv
// Shared types and limits for the ROM arbiter.
// Optional feature macro used by the top: ROM_ARBITER_ROUND_ROBIN_EN.
package rom_arbiter_pkg;

  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rom_arbiter_pick.sv
// Winner selection: picks the lowest requesting index strictly above ptr,
// wrapping around. Result is one-hot, or zero when nothing is requesting.
module rom_arbiter_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [PTR_W:0]   shift_s;
  logic [NREQ-1:0]  rot_s;
  logic [NREQ-1:0]  low_s;

  // Rotate so index ptr+1 lands at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    shift_s = {1'b0, ptr} + (PTR_W + 1)'(1'b1);
    rot_s   = NREQ'({req, req} >> shift_s);
    low_s   = rot_s & (~rot_s + NREQ'(1'b1));
    grant   = NREQ'(({low_s, low_s} << shift_s) >> NREQ);
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates NREQ read requesters onto one synchronous ROM (1-cycle latency).
// Define ROM_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr,
  output logic [NREQ-1:0]                 req_ready,
  output logic [NREQ-1:0]                 rsp_valid,
  input  logic [NREQ-1:0]                 rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rom_ce,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]           rom_dout
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                 state_q, state_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [NREQ-1:0]        pick_s;
  logic [PTR_W-1:0]       ptr_s;
  logic                   issue_s;
  logic [NREQ-1:0]        req_ready_s;
  logic                   rom_ce_s;
  logic [ADDR_WIDTH-1:0]  rom_addr_s;

  rom_arbiter_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_s),
    .grant (pick_s)
  );

`ifdef ROM_ARBITER_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] pick_idx_s;

  // Remember the index of the most recent winner.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_idx_s = pick_idx_s | (pick_s[i] ? PTR_W'(i) : '0);
    end
    ptr_d = issue_s ? pick_idx_s : ptr_q;
  end

  // Pointer register; reset value gives requester 0 first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= PTR_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  // A constant pointer of NREQ-1 makes the rotating pick a plain fixed priority.
  assign ptr_s = PTR_W'(NREQ - 1);
`endif

  // Next-state and request-side decode; issue_s marks a grant in this cycle.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    issue_s     = 1'b0;
    case (state_q)
      IDLE: begin
        issue_s = |req_valid;
      end
      READ: begin
        rsp_data_d  = rom_dout;
        rsp_valid_d = grant_q;
        state_d     = RESP;
      end
      RESP: begin
        if (|(rsp_valid_q & rsp_ready)) begin
          rsp_valid_d = '0;
          issue_s     = |req_valid;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue_s) begin
      req_ready_s = pick_s;
      rom_ce_s    = 1'b1;
      grant_d     = pick_s;
      state_d     = READ;
      rom_addr_s  = '0;
      for (int i = 0; i < NREQ; i++) begin
        rom_addr_s = rom_addr_s | (pick_s[i] ? req_addr[i] : '0);
      end
    end else begin
      req_ready_s = '0;
      rom_ce_s    = 1'b0;
      rom_addr_s  = '0;
    end
  end

  // State, latched grant and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Grant-side outputs must be same-cycle; reset forces them low at once.
  assign req_ready = reset ? '0   : req_ready_s;
  assign rom_ce    = reset ? 1'b0 : rom_ce_s;
  assign rom_addr  = reset ? '0   : rom_addr_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomised bench for rom_arbiter with a transaction-level reference model
// plus directed checks with hand-computed values.
module tb_rom_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 2;

  logic                   clk;
  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          rsp_valid;
  logic [NR-1:0]          rsp_ready;
  logic [DW-1:0]          rsp_data;
  logic                   rom_ce;
  logic [AW-1:0]          rom_addr;
  logic [DW-1:0]          rom_dout;

  logic [DW-1:0] rom_mem [256];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous ROM, one cycle of read latency.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom_mem[rom_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    if (last < 0) return -1;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
`else
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Reference model: at most one outstanding access, response visible two
  // cycles after acceptance, retired by its owner's rsp_ready.
  bit            m_busy  = 1'b0;
  int            m_owner = 0;
  int            m_from  = 0;
  int            m_last  = NR - 1;
  logic [DW-1:0] m_data  = '0;

  always @(negedge clk) begin
    logic [NR-1:0] e_rv;
    logic [NR-1:0] e_rr;
    logic          e_ce;
    logic [AW-1:0] e_addr;
    bit            hs;
    int            w;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rom_ce", rom_ce, 0);
      m_busy = 1'b0;
      m_last = NR - 1;
    end else begin
      e_rv = '0;
      if (m_busy && cyc >= m_from) e_rv[m_owner] = 1'b1;
      hs = (e_rv != 0) && rsp_ready[m_owner];
      w  = -1;
      if ((!m_busy || hs) && req_valid != 0) w = pick(req_valid, m_last);
      e_rr   = '0;
      e_ce   = 1'b0;
      e_addr = '0;
      if (w >= 0) begin
        e_rr[w] = 1'b1;
        e_ce    = 1'b1;
        e_addr  = req_addr[w];
      end
      chk("model_req_ready", req_ready, e_rr);
      chk("model_rom_ce", rom_ce, e_ce);
      chk("model_rom_addr", rom_addr, e_addr);
      chk("model_rsp_valid", rsp_valid, e_rv);
      if (e_rv != 0) chk("model_rsp_data", rsp_data, m_data);
      if (hs) m_busy = 1'b0;
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_data  = rom_mem[e_addr];
        m_from  = cyc + 2;
        m_last  = w;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [NR-1:0] cont_exp [8];

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    req_addr  = '0;
    rsp_ready = '0;
    rom_dout  = '0;
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[8'h10] = 32'hDEADBEEF;
    rom_mem[8'h20] = 32'hCAFEF00D;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    cont_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`else
    cont_exp = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
`endif

    // Reset state, with requests present to show the grant path is held off.
    @(negedge clk);
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rom_ce", rom_ce, 1'b0);
    chk("reset_rom_addr", rom_addr, 8'h00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_data", rsp_data, 32'h0);
    tick();
    do_reset();

    // Single request: grant in N, response in N+2.
    req_valid = 2'b01; req_addr[0] = 8'h10; rsp_ready = 2'b11;
    @(negedge clk);
    chk("single_req_ready", req_ready, 2'b01);
    chk("single_rom_ce", rom_ce, 1'b1);
    chk("single_rom_addr", rom_addr, 8'h10);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_read_ce", rom_ce, 1'b0);
    chk("single_read_rsp_valid", rsp_valid, 2'b00);
    tick();
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
    tick();

    // Contention with both requesters held valid.
    do_reset();
    req_valid = 2'b11; req_addr[0] = 8'h01; req_addr[1] = 8'h02; rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("contention_grant", req_ready, cont_exp[k]);
      tick();
    end
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    req_valid = 2'b01; req_addr[0] = 8'h10; rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; req_addr[1] = 8'h20; rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_read_req_ready", req_ready, 2'b00);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_rsp_valid", rsp_valid, 2'b01);
      chk("bp_hold_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("bp_hold_rom_ce", rom_ce, 1'b0);
      chk("bp_hold_req_ready", req_ready, 2'b00);
      tick();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_hs_req_ready", req_ready, 2'b10);
    chk("bp_hs_rom_ce", rom_ce, 1'b1);
    chk("bp_hs_rom_addr", rom_addr, 8'h20);
    tick();
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick(); tick(); tick();

    // Reset asserted while a read is in flight.
    req_valid = 2'b01; req_addr[0] = 8'h10;
    tick();
    reset = 1'b1; req_valid = 2'b11;
    #1;
    chk("rstread_req_ready", req_ready, 2'b00);
    chk("rstread_rom_ce", rom_ce, 1'b0);
    chk("rstread_rom_addr", rom_addr, 8'h00);
    chk("rstread_rsp_valid", rsp_valid, 2'b00);
    chk("rstread_rsp_data", rsp_data, 32'h0);
    tick(); tick();
    reset = 1'b0; req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstread_no_rsp", rsp_valid, 2'b00);
      tick();
    end
    req_valid = 2'b11;
    @(negedge clk);
    chk("rstread_next_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Ready on the wrong port must not complete the response.
    do_reset();
    req_valid = 2'b01; req_addr[0] = 8'h10; rsp_ready = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrongport_rsp_valid", rsp_valid, 2'b01);
      tick();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("wrongport_hs_rsp_valid", rsp_valid, 2'b01);
    tick();
    @(negedge clk);
    chk("wrongport_after_rsp_valid", rsp_valid, 2'b00);
    tick();

    // Random traffic, checked cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid   = NR'($urandom);
      req_addr[0] = AW'($urandom);
      req_addr[1] = AW'($urandom);
      rsp_ready   = NR'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, ROM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM word width.
REQ-003 SHALL have parameter NREQ, default 2, number of requesters; legal range 1..8.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester read request.
REQ-007 SHALL have port req_addr  input  NREQ x ADDR_WIDTH  per-requester word address.
REQ-008 SHALL have port req_ready  output  NREQ  request accepted this cycle (one-hot or zero).
REQ-009 SHALL have port rsp_valid  output  NREQ  response data valid for that requester (one-hot or zero).
REQ-010 SHALL have port rsp_ready  input  NREQ  requester consumes response.
REQ-011 SHALL have port rsp_data  output  DATA_WIDTH  registered response word, shared by all requesters.
REQ-012 SHALL have ports rom_ce  output  1, rom_addr  output  ADDR_WIDTH, rom_dout  input  DATA_WIDTH, driving one single-ported synchronous ROM with 1-cycle read latency.

Function
REQ-013 SHALL implement FSM states IDLE, READ, RESP.
REQ-014 IDLE: if any req_valid, SHALL grant one winner g, assert req_ready[g], rom_ce=1, rom_addr=req_addr[g], latch g, go READ; otherwise stay IDLE with rom_ce=0.
REQ-015 READ: SHALL hold rom_ce=0, capture rom_dout into rsp_data at the clock edge, go RESP.
REQ-016 RESP: SHALL assert rsp_valid[g] with rsp_data stable until rsp_ready[g] is high.
REQ-017 On the RESP handshake cycle, if any req_valid is high, SHALL grant and issue the next ROM read in that same cycle and go READ; otherwise go IDLE.
REQ-018 Request accepted in cycle N SHALL produce rsp_valid in cycle N+2; sustained throughput SHALL be one access per 2 cycles.
REQ-019 rsp_ready of non-granted requesters SHALL be ignored; req_valid changes during READ/RESP SHALL not affect the in-flight access.
REQ-020 req_ready SHALL be asserted only in IDLE or on the RESP handshake cycle, never in READ.
REQ-021 rom_addr SHALL be don't-care-free: 0 whenever rom_ce=0.
REQ-022 With NREQ=1 the block SHALL behave identically with g fixed at 0.

Reset
REQ-023 Reset SHALL force state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rom_ce=0, latched grant=0, round-robin pointer=NREQ-1 (so requester 0 has highest priority first).
REQ-024 Reset asserted mid-access SHALL drop the in-flight access with no response delivered after reset release.

Configuration
REQ-025 With macro ROM_ARBITER_ROUND_ROBIN_EN defined, SHALL select the lowest index above the last granted index (wrapping), and update the pointer on every grant.
REQ-026 Without ROM_ARBITER_ROUND_ROBIN_EN, SHALL use fixed priority (lowest asserted index wins) and SHALL contain no pointer register.

Structure
REQ-027 A shared package rom_arbiter_pkg SHALL hold the FSM state enum (IDLE, READ, RESP) and the NREQ maximum constant (8).
REQ-028 The winner selection SHALL be one sub-module rom_arbiter_pick (inputs: request vector, pointer; output: one-hot grant).
REQ-029 The ROM itself SHALL stay outside this block.

Verification
REQ-030 Single request: req_valid=01, req_addr[0]=0x10, ROM[0x10]=0xDEADBEEF, rsp_ready high -> req_ready=01 cycle N, rom_ce=1 cycle N, rsp_valid=01 and rsp_data=0xDEADBEEF cycle N+2.
REQ-031 Contention, round-robin built: req_valid=11 held, addrs 0x01/0x02 -> grant order 0,1,0,1; one response every 2 cycles; without macro -> grants 0,0,0,0.
REQ-032 Backpressure: rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_data held stable 5 cycles, rom_ce=0, req_ready=00 throughout; the request pending on requester 1 is granted on the handshake cycle.
REQ-033 Reset in READ: assert reset one cycle after grant -> all outputs zero immediately (asynchronous), no rsp_valid after release, next grant goes to requester 0.
REQ-034 Wrong-port ready: rsp_valid=01, rsp_ready=10 -> state remains RESP, rsp_valid stays 01.
